// File: rtl/error_monitor.sv
// -----------------------------------------------------------------------------
// error_monitor
//
// Lock-step comparator for two cores. Every cycle in RUN it compares the
// register writeback streams of core 0 and core 1. On a divergence it raises a
// one-cycle error pulse to the recovery controller and halts both cores. It
// then waits for the controller to report that replay is complete. If the
// controller does not answer within TIMEOUT cycles, the monitor locks into a
// sticky FATAL state that only reset can clear.
//
// Handshake with the recovery controller: error_o is a single-cycle pulse with
// no ready/ack. The controller answers with a done_i pulse. done_i is only
// observed in WAIT_DONE and is ignored in every other state.
//
// Parameters
//   ADDR_WIDTH  register address width                  (default 5)
//   DATA_WIDTH  writeback data width                    (default 32)
//   TIMEOUT     max cycles spent waiting for done_i     (default 64, >= 2)
//   CNT_WIDTH   saturating error counter width          (default 8)
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   synchronous, active-high reset
//   core0_valid_i  in   core 0 writeback valid
//   core0_addr_i   in   core 0 writeback register address
//   core0_data_i   in   core 0 writeback data
//   core1_valid_i  in   core 1 writeback valid
//   core1_addr_i   in   core 1 writeback register address
//   core1_data_i   in   core 1 writeback data
//   done_i         in   replay-complete pulse from the recovery controller
//   error_o        out  one-cycle error pulse (registered)
//   halt_o         out  stall both cores while high (registered)
//   fatal_o        out  sticky unrecoverable-fault flag (registered)
//   err_count_o    out  number of detected errors, saturating (registered)
//   dbg_state_o    out  current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module error_monitor #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core0_valid_i,
  input  logic [ADDR_WIDTH-1:0] core0_addr_i,
  input  logic [DATA_WIDTH-1:0] core0_data_i,
  input  logic                  core1_valid_i,
  input  logic [ADDR_WIDTH-1:0] core1_addr_i,
  input  logic [DATA_WIDTH-1:0] core1_data_i,
  input  logic                  done_i,
  output logic                  error_o,
  output logic                  halt_o,
  output logic                  fatal_o,
  output logic [CNT_WIDTH-1:0]  err_count_o,
  output logic [2:0]            dbg_state_o
);

  // Wide enough to hold TIMEOUT-1 with one bit of headroom.
  localparam int TMO_WIDTH = $clog2(TIMEOUT) + 1;
  localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    SIGNAL    = 3'd1,
    WAIT_DONE = 3'd2,
    RESUME    = 3'd3,
    FATAL     = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [TMO_WIDTH-1:0]  r_tmo;
  logic [CNT_WIDTH-1:0]  r_err_count;
  logic                  r_error;
  logic                  r_halt;
  logic                  r_fatal;

  logic                  w_mismatch;
  logic                  w_count_en;
  logic                  w_tmo_expired;

  // Divergence detection. Both sides idle is agreement. One side writing back
  // while the other does not is a divergence. Both writing back must agree on
  // both the address and the data.
  always_comb begin
    w_mismatch = 1'b0;
    if (core0_valid_i != core1_valid_i) begin
      w_mismatch = 1'b1;
    end else if (core0_valid_i && core1_valid_i) begin
      w_mismatch = (core0_addr_i != core1_addr_i) ||
                   (core0_data_i != core1_data_i);
    end
  end

  assign w_tmo_expired = (r_tmo == TMO_LAST);

  // Next-state logic. Core inputs are only consulted in RUN. done_i is only
  // consulted in WAIT_DONE, and it takes priority over the timeout.
  always_comb begin
    w_next     = r_state;
    w_count_en = 1'b0;
    case (r_state)
      RUN: begin
        if (w_mismatch) begin
          w_next     = SIGNAL;
          w_count_en = 1'b1;
        end
      end
      SIGNAL: begin
        w_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_i) begin
          w_next = RESUME;
        end else if (w_tmo_expired) begin
          w_next = FATAL;
        end
      end
      RESUME: begin
        // The cores are refilling their pipelines, so this cycle's writeback
        // streams are not compared.
        w_next = RUN;
      end
      FATAL: begin
        w_next = FATAL;
      end
      default: begin
        w_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // Timeout counter. It is cleared while the FSM is entering WAIT_DONE, so the
  // first WAIT_DONE cycle sees 0. It then advances once per WAIT_DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo <= '0;
    end else if (r_state == WAIT_DONE) begin
      r_tmo <= r_tmo + 1'b1;
    end else begin
      r_tmo <= '0;
    end
  end

  // Error counter: counts entries into SIGNAL and holds at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (w_count_en && (r_err_count != {CNT_WIDTH{1'b1}})) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  // The outputs are registered from the next state. Each flop therefore
  // mirrors the state it belongs to, with no combinational path from the
  // inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_error <= 1'b0;
      r_halt  <= 1'b0;
      r_fatal <= 1'b0;
    end else begin
      r_error <= (w_next == SIGNAL);
      r_halt  <= (w_next == SIGNAL) || (w_next == WAIT_DONE) ||
                 (w_next == FATAL);
      r_fatal <= (w_next == FATAL);
    end
  end

  assign error_o     = r_error;
  assign halt_o      = r_halt;
  assign fatal_o     = r_fatal;
  assign err_count_o = r_err_count;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_error_monitor.sv
// -----------------------------------------------------------------------------
// tb_error_monitor
//
// Directed bench for error_monitor with its default parameters.
// - Inputs are driven 1 ns after a rising edge.
// - Outputs are sampled at that same point, before the new inputs are applied.
// - Every step() advances exactly one clock edge.
// -----------------------------------------------------------------------------
module tb_error_monitor;

  localparam int AW      = 5;
  localparam int DW      = 32;
  localparam int TMO     = 64;
  localparam int CW      = 8;
  localparam int CNT_MAX = 255;

  localparam logic [2:0] S_RUN    = 3'd0;
  localparam logic [2:0] S_SIGNAL = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_RESUME = 3'd3;
  localparam logic [2:0] S_FATAL  = 3'd4;

  logic          clk;
  logic          rst;
  logic          core0_valid_i;
  logic [AW-1:0] core0_addr_i;
  logic [DW-1:0] core0_data_i;
  logic          core1_valid_i;
  logic [AW-1:0] core1_addr_i;
  logic [DW-1:0] core1_data_i;
  logic          done_i;
  logic          error_o;
  logic          halt_o;
  logic          fatal_o;
  logic [CW-1:0] err_count_o;
  logic [2:0]    dbg_state_o;

  int n_compared;
  int n_mismatched;
  int exp_cnt;

  error_monitor #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TMO),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .core0_valid_i (core0_valid_i),
    .core0_addr_i  (core0_addr_i),
    .core0_data_i  (core0_data_i),
    .core1_valid_i (core1_valid_i),
    .core1_addr_i  (core1_addr_i),
    .core1_data_i  (core1_data_i),
    .done_i        (done_i),
    .error_o       (error_o),
    .halt_o        (halt_o),
    .fatal_o       (fatal_o),
    .err_count_o   (err_count_o),
    .dbg_state_o   (dbg_state_o)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checker
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Check all four architectural outputs and the state in one go.
  task automatic check_all(input string tag, input logic [2:0] st,
                           input logic err, input logic hlt, input logic fat,
                           input int cnt);
    check({tag, ".state"}, 32'(dbg_state_o), 32'(st));
    check({tag, ".error"}, 32'(error_o), 32'(err));
    check({tag, ".halt"},  32'(halt_o), 32'(hlt));
    check({tag, ".fatal"}, 32'(fatal_o), 32'(fat));
    check({tag, ".count"}, 32'(err_count_o), 32'(cnt));
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cores(input logic v0, input logic [AW-1:0] a0,
                             input logic [DW-1:0] d0, input logic v1,
                             input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    core0_valid_i = v0;
    core0_addr_i  = a0;
    core0_data_i  = d0;
    core1_valid_i = v1;
    core1_addr_i  = a1;
    core1_data_i  = d1;
  endtask

  task automatic drive_match();
    drive_cores(1'b1, 5'd3, 32'hDEADBEEF, 1'b1, 5'd3, 32'hDEADBEEF);
  endtask

  task automatic bump_expected();
    if (exp_cnt < CNT_MAX) exp_cnt++;
  endtask

  // One complete error/recovery round, returning to RUN.
  task automatic error_round(input int kind);
    case (kind % 3)
      0: drive_cores(1'b1, 5'd5, 32'h1, 1'b1, 5'd5, 32'h2); // data differs
      1: drive_cores(1'b1, 5'd1, 32'h7, 1'b1, 5'd2, 32'h7); // addr differs
      default: drive_cores(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0); // valid
    endcase
    step();                     // -> SIGNAL
    bump_expected();
    drive_match();
    step();                     // -> WAIT_DONE
    done_i = 1'b1;
    step();                     // -> RESUME
    done_i = 1'b0;
    step();                     // -> RUN
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int saw_error;
    int saw_halt;
    int prev_err;
    int double_err;

    n_compared   = 0;
    n_mismatched = 0;
    exp_cnt      = 0;
    rst          = 1'b1;
    done_i       = 1'b0;
    drive_cores(1'b0, '0, '0, 1'b0, '0, '0);

    // Reset state.
    step();
    step();
    check_all("reset", S_RUN, 1'b0, 1'b0, 1'b0, 0);
    rst = 1'b0;

    // Matching streams for 100 cycles: no error, no halt, no count.
    drive_match();
    saw_error = 0;
    saw_halt  = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (error_o) saw_error++;
      if (halt_o)  saw_halt++;
    end
    check("match100.error_cycles", 32'(saw_error), 32'd0);
    check("match100.halt_cycles",  32'(saw_halt),  32'd0);
    check_all("match100", S_RUN, 1'b0, 1'b0, 1'b0, 0);

    // Both invalid with different addr/data is not a divergence.
    drive_cores(1'b0, 5'd1, 32'h11, 1'b0, 5'd2, 32'h22);
    step();
    check_all("both_idle", S_RUN, 1'b0, 1'b0, 1'b0, 0);

    // Data mismatch at addr 5: the error pulse appears one edge later.
    drive_cores(1'b1, 5'd5, 32'h1, 1'b1, 5'd5, 32'h2);
    step();
    bump_expected();
    check_all("data_mm.signal", S_SIGNAL, 1'b1, 1'b1, 1'b0, exp_cnt);
    drive_match();
    step();
    check_all("data_mm.wait", S_WAIT, 1'b0, 1'b1, 1'b0, exp_cnt);
    repeat (8) step();
    check_all("data_mm.wait8", S_WAIT, 1'b0, 1'b1, 1'b0, exp_cnt);
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    check_all("data_mm.resume", S_RESUME, 1'b0, 1'b0, 1'b0, exp_cnt);
    step();
    check_all("data_mm.run", S_RUN, 1'b0, 1'b0, 1'b0, exp_cnt);

    // Valid mismatch. Keep the mismatch applied through WAIT_DONE and
    // RESUME; it must add nothing.
    drive_cores(1'b1, 5'd5, 32'h1, 1'b0, 5'd5, 32'h1);
    step();
    bump_expected();
    check_all("valid_mm.signal", S_SIGNAL, 1'b1, 1'b1, 1'b0, exp_cnt);
    step();
    check_all("valid_mm.wait", S_WAIT, 1'b0, 1'b1, 1'b0, exp_cnt);
    repeat (3) step();
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    check_all("valid_mm.resume", S_RESUME, 1'b0, 1'b0, 1'b0, exp_cnt);
    step();                    // mismatch sampled in RESUME is suppressed
    check_all("valid_mm.run", S_RUN, 1'b0, 1'b0, 1'b0, exp_cnt);
    drive_match();
    step();
    check_all("valid_mm.quiet", S_RUN, 1'b0, 1'b0, 1'b0, exp_cnt);

    // done_i arriving on the very cycle the counter reaches TIMEOUT-1 wins.
    drive_cores(1'b1, 5'd1, 32'h0, 1'b1, 5'd2, 32'h0);
    step();
    bump_expected();
    drive_match();
    step();                    // first WAIT_DONE cycle, counter 0
    repeat (TMO - 1) step();   // counter now TIMEOUT-1
    check_all("edge.wait_last", S_WAIT, 1'b0, 1'b1, 1'b0, exp_cnt);
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    check_all("edge.resume", S_RESUME, 1'b0, 1'b0, 1'b0, exp_cnt);
    step();

    // No done_i at all: exactly TIMEOUT WAIT_DONE cycles, then FATAL.
    drive_cores(1'b1, 5'd5, 32'h1, 1'b1, 5'd5, 32'h2);
    step();
    bump_expected();
    drive_match();
    step();
    repeat (TMO - 1) step();
    check("tmo.not_yet", 32'(dbg_state_o), 32'(S_WAIT));
    step();
    check_all("tmo.fatal", S_FATAL, 1'b0, 1'b1, 1'b1, exp_cnt);
    // FATAL is sticky: done_i and fresh mismatches are ignored.
    done_i = 1'b1;
    drive_cores(1'b1, 5'd5, 32'h1, 1'b0, 5'd5, 32'h1);
    repeat (5) step();
    done_i = 1'b0;
    check_all("tmo.sticky", S_FATAL, 1'b0, 1'b1, 1'b1, exp_cnt);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = 0;
    drive_match();
    check_all("tmo.reset", S_RUN, 1'b0, 1'b0, 1'b0, 0);

    // 300 isolated errors: the counter saturates at 255.
    // error_o must never be high on two consecutive samples.
    prev_err   = 0;
    double_err = 0;
    for (int i = 0; i < 300; i++) begin
      error_round(i);
      if (i == 99) check("sat.count100", 32'(err_count_o), 32'(exp_cnt));
      if (i == 254) check("sat.count255", 32'(err_count_o), 32'(exp_cnt));
    end
    check("sat.count300", 32'(err_count_o), 32'(CNT_MAX));
    check("sat.model", 32'(exp_cnt), 32'(CNT_MAX));

    // Back-to-back error pulses: a mismatch held continuously.
    drive_cores(1'b1, 5'd5, 32'h1, 1'b1, 5'd5, 32'h2);
    for (int i = 0; i < 4; i++) begin
      step();
      if (error_o && prev_err != 0) double_err++;
      prev_err = int'(error_o);
    end
    check("pulse.single", 32'(double_err), 32'd0);
    check_all("pulse.wait", S_WAIT, 1'b0, 1'b1, 1'b0, CNT_MAX);

    // Reset in WAIT_DONE, with done_i and a mismatch also present: reset wins.
    done_i = 1'b1;
    rst    = 1'b1;
    step();
    rst    = 1'b0;
    done_i = 1'b0;
    drive_match();
    check_all("rst_wait", S_RUN, 1'b0, 1'b0, 1'b0, 0);
    step();
    check_all("rst_wait.after", S_RUN, 1'b0, 1'b0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_compared, n_mismatched);
    $finish;
  end

  // Global time guard so the run always ends on its own.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
